// File: rtl/arm_fetch_decode.sv
// ARM32 fetch/decode front end: streams words from a sync-read RAM into a small
// {pc, ins} FIFO and presents decoded fields with condition evaluation.
module arm_fetch_decode #(
  parameter int              ARCH       = 32,
  parameter int              RAM_SIZE   = 4096,
  parameter int              ADDR_W     = $clog2(RAM_SIZE),
  parameter int              FIFO_DEPTH = 2,
  parameter logic [ARCH-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [ARCH-1:0]   mem_rdata,
  input  logic              redirect_valid,
  input  logic [ARCH-1:0]   redirect_pc,
  input  logic [3:0]        nzcv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ARCH-1:0]   out_pc,
  output logic [ARCH-1:0]   out_ins,
  output logic [3:0]        out_cond,
  output logic [1:0]        out_class,
  output logic              out_imm,
  output logic [3:0]        out_opcode,
  output logic              out_s,
  output logic [3:0]        out_rn,
  output logic [3:0]        out_rd,
  output logic [11:0]       out_imm12,
  output logic              out_cond_pass
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;
  // Fetch PC lives in a 4*RAM_SIZE byte window; increments wrap inside it.
  localparam logic [ARCH-1:0] PC_MASK =
    (ADDR_W + 2 >= ARCH) ? '1 : ARCH'((64'd1 << (ADDR_W + 2)) - 64'd1);

  typedef struct packed {
    logic [ARCH-1:0] pc;
    logic [ARCH-1:0] ins;
  } entry_t;

  logic [ARCH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ARCH-1:0]  tag_q, tag_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  entry_t [FIFO_DEPTH-1:0] fifo_q;

  logic             empty, push, pop;
  logic [OCC_W-1:0] occ, limit;
  entry_t           head;
  logic [ARCH-1:0]  ins;
  logic             unused_pc_lsb;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'b0000: return z;
      4'b0001: return !z;
      4'b0010: return cf;
      4'b0011: return !cf;
      4'b0100: return n;
      4'b0101: return !n;
      4'b0110: return v;
      4'b0111: return !v;
      4'b1000: return cf & !z;
      4'b1001: return !cf | z;
      4'b1010: return n == v;
      4'b1011: return n != v;
      4'b1100: return !z & (n == v);
      4'b1101: return z | (n != v);
      default: return 1'b1;
    endcase
  endfunction

  assign unused_pc_lsb = ^redirect_pc[1:0];

  assign empty     = (count_q == '0);
  assign out_valid = !empty & !redirect_valid;
  assign pop       = out_valid & out_ready;
  // A response landing during a redirect belongs to the flushed stream.
  assign push      = inflight_q & !redirect_valid;

  // Pop frees a slot this cycle, so a full FIFO can still issue.
  assign occ    = OCC_W'(count_q) + OCC_W'(inflight_q);
  assign limit  = OCC_W'(FIFO_DEPTH) + OCC_W'(pop);
  assign mem_en = reset_n & !redirect_valid & (occ < limit);
  assign mem_addr = fetch_pc_q[ADDR_W+1:2];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    tag_d      = tag_q;
    inflight_d = mem_en;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[ARCH-1:2], 2'b00};
      inflight_d = 1'b0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (mem_en) begin
        fetch_pc_d = (fetch_pc_q + ARCH'(4)) & PC_MASK;
        tag_d      = fetch_pc_q;
      end
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      fifo_q[wr_ptr_q].pc  <= tag_q;
      fifo_q[wr_ptr_q].ins <= mem_rdata;
    end
  end

  assign head    = fifo_q[rd_ptr_q];
  assign ins     = empty ? '0 : head.ins;
  assign out_pc  = empty ? '0 : head.pc;
  assign out_ins = ins;

  assign out_cond   = ins[31:28];
  assign out_imm    = ins[25];
  assign out_opcode = ins[24:21];
  assign out_s      = ins[20];
  assign out_rn     = ins[19:16];
  assign out_rd     = ins[15:12];
  assign out_imm12  = ins[11:0];

  always_comb begin
    if (ins[27:26] == 2'b00)       out_class = 2'b00;
    else if (ins[27:26] == 2'b01)  out_class = 2'b01;
    else if (ins[27:25] == 3'b101) out_class = 2'b10;
    else                           out_class = 2'b11;
  end

  assign out_cond_pass = !empty & cond_eval(ins[31:28], nzcv);

endmodule

// File: tb/tb_arm_fetch_decode.sv
// Directed bench for arm_fetch_decode: stream, backpressure, redirect, decode,
// mid-stream reset, plus a small-RAM instance that exercises PC wrap.
module tb_arm_fetch_decode;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [3:0]  nzcv;
  logic        out_ready;

  logic        mem_en;
  logic [11:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        out_valid, out_imm, out_s, out_cond_pass;
  logic [31:0] out_pc, out_ins;
  logic [3:0]  out_cond, out_opcode, out_rn, out_rd;
  logic [1:0]  out_class;
  logic [11:0] out_imm12;

  logic        w_mem_en;
  logic [3:0]  w_mem_addr;
  logic [31:0] w_mem_rdata;
  logic        w_out_valid, w_out_imm, w_out_s, w_out_cond_pass;
  logic [31:0] w_out_pc, w_out_ins;
  logic [3:0]  w_out_cond, w_out_opcode, w_out_rn, w_out_rd;
  logic [1:0]  w_out_class;
  logic [11:0] w_out_imm12;

  logic [31:0] ram  [4096];
  logic [31:0] ram2 [16];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en)   mem_rdata   <= ram[mem_addr];
  always @(posedge clk) if (w_mem_en) w_mem_rdata <= ram2[w_mem_addr];

  arm_fetch_decode u_dut (
    .clk(clk), .reset_n(reset_n), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .nzcv(nzcv), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_ins(out_ins), .out_cond(out_cond), .out_class(out_class), .out_imm(out_imm),
    .out_opcode(out_opcode), .out_s(out_s), .out_rn(out_rn), .out_rd(out_rd),
    .out_imm12(out_imm12), .out_cond_pass(out_cond_pass)
  );

  arm_fetch_decode #(.RAM_SIZE(16), .RESET_PC(32'h38)) u_wrap (
    .clk(clk), .reset_n(reset_n), .mem_en(w_mem_en), .mem_addr(w_mem_addr),
    .mem_rdata(w_mem_rdata), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .nzcv(nzcv), .out_valid(w_out_valid), .out_ready(1'b1), .out_pc(w_out_pc),
    .out_ins(w_out_ins), .out_cond(w_out_cond), .out_class(w_out_class), .out_imm(w_out_imm),
    .out_opcode(w_out_opcode), .out_s(w_out_s), .out_rn(w_out_rn), .out_rd(w_out_rd),
    .out_imm12(w_out_imm12), .out_cond_pass(w_out_cond_pass)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle; inputs are then changed and checked #1 later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    out_ready = 1'b1; nzcv = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 32'hE081_0002 + i;
    ram[12'h200] = 32'h0A00_0010;
    ram[12'h201] = 32'hD591_2004;
    for (int i = 0; i < 16; i++) ram2[i] = 32'hA000_0000 + i;

    // Reset state
    do_reset();
    #1;
    check("rst_valid",    32'(out_valid), 32'd0);
    check("rst_mem_en",   32'(mem_en), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_ins",      out_ins, 32'd0);
    check("rst_class",    32'(out_class), 32'd0);
    check("rst_condpass", 32'(out_cond_pass), 32'd0);
    check("rst_wrap_addr", 32'(w_mem_addr), 32'd14);

    // Sequential stream
    reset_n = 1'b1; #1;
    check("c0_mem_en", 32'(mem_en), 32'd1);
    check("c0_valid",  32'(out_valid), 32'd0);
    tick(); #1;
    check("c1_valid",    32'(out_valid), 32'd0);
    check("c1_mem_addr", 32'(mem_addr), 32'd1);
    for (int k = 2; k <= 7; k++) begin
      tick(); #1;
      check("str_valid", 32'(out_valid), 32'd1);
      check("str_pc",    out_pc, 32'(4 * (k - 2)));
      check("str_ins",   out_ins, 32'hE081_0002 + 32'(k - 2));
    end
    tick(); #1;
    check("str_class",  32'(out_class), 32'd0);
    check("str_opcode", 32'(out_opcode), 32'd4);
    check("str_rn",     32'(out_rn), 32'd1);
    check("str_rd",     32'(out_rd), 32'd0);
    check("str_pass",   32'(out_cond_pass), 32'd1);

    // Wrap instance ran alongside; re-reset and watch it from cycle 2
    do_reset();
    reset_n = 1'b1;
    tick();
    tick(); #1;
    check("wrap_pc0",  w_out_pc, 32'h38);
    check("wrap_ins0", w_out_ins, 32'hA000_000E);
    tick(); #1;
    check("wrap_pc1",  w_out_pc, 32'h3C);
    tick(); #1;
    check("wrap_pc2",  w_out_pc, 32'h00);
    check("wrap_ins2", w_out_ins, 32'hA000_0000);
    tick(); #1;
    check("wrap_pc3",  w_out_pc, 32'h04);

    // Backpressure: ready low for cycles 3..10
    do_reset();
    reset_n = 1'b1;
    tick(); tick(); tick();
    out_ready = 1'b0; #1;
    check("bp_c3_mem_en", 32'(mem_en), 32'd0);
    check("bp_c3_pc",     out_pc, 32'h4);
    for (int k = 4; k <= 10; k++) begin
      tick(); #1;
      check("bp_hold_mem_en", 32'(mem_en), 32'd0);
      check("bp_hold_pc",     out_pc, 32'h4);
    end
    check("bp_hold_ins", out_ins, 32'hE081_0003);
    tick(); out_ready = 1'b1; #1;
    check("bp_c11_pc",     out_pc, 32'h4);
    check("bp_c11_mem_en", 32'(mem_en), 32'd1);
    check("bp_c11_addr",   32'(mem_addr), 32'd3);
    for (int k = 12; k <= 14; k++) begin
      tick(); #1;
      check("bp_rel_valid", 32'(out_valid), 32'd1);
      check("bp_rel_pc",    out_pc, 32'(4 * (k - 10)));
    end

    // Redirect in cycle 6 to 0x103
    do_reset();
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h103; #1;
    check("rd_c6_valid",  32'(out_valid), 32'd0);
    check("rd_c6_mem_en", 32'(mem_en), 32'd0);
    tick(); redirect_valid = 1'b0; #1;
    check("rd_c7_mem_en", 32'(mem_en), 32'd1);
    check("rd_c7_addr",   32'(mem_addr), 32'h40);
    check("rd_c7_valid",  32'(out_valid), 32'd0);
    tick(); #1;
    check("rd_c8_valid", 32'(out_valid), 32'd0);
    tick(); #1;
    check("rd_c9_valid", 32'(out_valid), 32'd1);
    check("rd_c9_pc",    out_pc, 32'h100);
    check("rd_c9_ins",   out_ins, 32'hE081_0042);
    tick(); #1;
    check("rd_c10_pc",   out_pc, 32'h104);

    // Condition and class decode with the head held by ready=0
    do_reset();
    reset_n = 1'b1; out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h800; #1;
    check("cc_c0_mem_en", 32'(mem_en), 32'd0);
    tick(); redirect_valid = 1'b0; #1;
    check("cc_c1_addr", 32'(mem_addr), 32'h200);
    tick();
    tick(); nzcv = 4'b0100; #1;
    check("beq_valid", 32'(out_valid), 32'd1);
    check("beq_pc",    out_pc, 32'h800);
    check("beq_class", 32'(out_class), 32'd2);
    check("beq_cond",  32'(out_cond), 32'd0);
    check("beq_imm",   32'(out_imm), 32'd1);
    check("beq_pass_z1", 32'(out_cond_pass), 32'd1);
    nzcv = 4'b0000; #1;
    check("beq_pass_z0", 32'(out_cond_pass), 32'd0);
    tick(); out_ready = 1'b1; nzcv = 4'b0100; #1;
    check("beq_pop_pc", out_pc, 32'h800);
    tick(); out_ready = 1'b0; #1;
    check("ldr_pc",     out_pc, 32'h804);
    check("ldr_class",  32'(out_class), 32'd1);
    check("ldr_cond",   32'(out_cond), 32'hD);
    check("ldr_imm",    32'(out_imm), 32'd0);
    check("ldr_opcode", 32'(out_opcode), 32'hC);
    check("ldr_s",      32'(out_s), 32'd1);
    check("ldr_rn",     32'(out_rn), 32'd1);
    check("ldr_rd",     32'(out_rd), 32'd2);
    check("ldr_imm12",  32'(out_imm12), 32'h004);
    check("ldr_pass_z1", 32'(out_cond_pass), 32'd1);
    nzcv = 4'b0000; #1;
    check("ldr_pass_0", 32'(out_cond_pass), 32'd0);
    nzcv = 4'b1000; #1;
    check("ldr_pass_nv", 32'(out_cond_pass), 32'd1);

    // Reset mid-stream at cycle 12 together with a redirect
    do_reset();
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    reset_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h500; #1;
    check("mr_c12_mem_en", 32'(mem_en), 32'd0);
    tick(); reset_n = 1'b1; redirect_valid = 1'b0; #1;
    check("mr_c13_valid",  32'(out_valid), 32'd0);
    check("mr_c13_mem_en", 32'(mem_en), 32'd1);
    check("mr_c13_addr",   32'(mem_addr), 32'd0);
    check("mr_c13_pc",     out_pc, 32'd0);
    tick(); #1;
    check("mr_c14_valid", 32'(out_valid), 32'd0);
    tick(); #1;
    check("mr_c15_valid", 32'(out_valid), 32'd1);
    check("mr_c15_pc",    out_pc, 32'd0);
    check("mr_c15_ins",   out_ins, 32'hE081_0002);
    tick(); #1;
    check("mr_c16_pc",    out_pc, 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
